// File: rtl/mod_add_pkg.sv
// Shared constants, side-band types and the round-robin search for the
// modular-adder arbiter.
package mod_add_pkg;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_MODULUS    = 177147;
  localparam int MAX_REQ        = 16;
  localparam int TAG_ID_W       = 4;

  // Side-band information travelling alongside the adder stages.
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
    logic                err;
  } tag_t;

  // Result of the round-robin search.
  typedef struct packed {
    logic                found;
    logic [TAG_ID_W-1:0] idx;
  } pick_t;

  // First set bit of vld[n-1:0], searching upward from ptr and wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  vld,
                                    input logic [TAG_ID_W-1:0] ptr,
                                    input int unsigned         n);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = 32'(ptr) + k;
        if (j >= n) j = j - n;
        if (!p.found && vld[TAG_ID_W'(j)]) begin
          p.found = 1'b1;
          p.idx   = TAG_ID_W'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mod_add_arbiter_mod_add_2stage.sv
// Two-register modular adder: result = (a + b + cin) mod MODULUS, 2-cycle latency.
module mod_add_2stage
  import mod_add_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH:0] MOD_EXT = (DATA_WIDTH + 1)'(MODULUS);

  logic [DATA_WIDTH:0] sum_q;

  // Stage 1: raw sum with one extra bit for the carry.
  always_ff @(posedge clk) begin
    sum_q <= {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
  end

  // Stage 2: single conditional subtraction brings in-range sums back below MODULUS.
  always_ff @(posedge clk) begin
    if (sum_q >= MOD_EXT) result <= DATA_WIDTH'(sum_q - MOD_EXT);
    else                  result <= sum_q[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/mod_add_arbiter.sv
// Round-robin arbiter sharing one pipelined modular adder among NUM_REQ
// requesters, with credit-based flow control into a tagged result FIFO.
module mod_add_arbiter
  import mod_add_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int OUT_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          res_err,
  output logic                          busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);

  logic [ID_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [MAX_REQ-1:0]    vld_ext;
  pick_t                 pick;
  logic                  can_issue;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  sel_cin;
  logic [DATA_WIDTH-1:0] sum_mod;
  tag_t                  tag1;
  tag_t                  tag2;
  logic                  unused_tag_id;

  logic [DATA_WIDTH-1:0] fifo_data [OUT_DEPTH];
  logic [ID_W-1:0]       fifo_id   [OUT_DEPTH];
  logic                  fifo_err  [OUT_DEPTH];

  // Arbitration: round-robin winner, operand mux and credit-gated ready.
  always_comb begin
    vld_ext                = '0;
    vld_ext[NUM_REQ-1:0]   = req_valid;
    pick                   = rr_pick(vld_ext, TAG_ID_W'(rr_ptr), NUM_REQ);
    can_issue              = (cnt < CNT_W'(OUT_DEPTH)) && !rst;
    issue                  = pick.found && can_issue;
    sel_a                  = '0;
    sel_b                  = '0;
    sel_cin                = 1'b0;
    req_ready              = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick.found && (pick.idx == TAG_ID_W'(i))) begin
        sel_a        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_cin      = req_cin[i];
        req_ready[i] = can_issue;
      end
    end
    sel_err = (sel_a >= DATA_WIDTH'(MODULUS)) || (sel_b >= DATA_WIDTH'(MODULUS));
  end

  mod_add_2stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODULUS    (MODULUS)
  ) u_add (
    .clk    (clk),
    .a      (sel_a),
    .b      (sel_b),
    .cin    (sel_cin),
    .result (sum_mod)
  );

  assign pop           = res_valid && res_ready;
  assign push          = tag2.vld;
  assign unused_tag_id = ^tag2.id;

  // Round-robin pointer advances past the winner on every issue.
  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= '0;
    else if (issue) rr_ptr <= (pick.idx == TAG_ID_W'(NUM_REQ - 1)) ? '0
                                                                   : ID_W'(pick.idx + 1'b1);
  end

  // Credits cover both adder stages plus FIFO occupancy, so the FIFO never overflows.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (issue && !pop) cnt <= cnt + 1'b1;
    else if (pop && !issue) cnt <= cnt - 1'b1;
  end

  // Side-band valid/id/err shift in lockstep with the adder registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      tag1 <= '{vld: issue, id: pick.idx, err: sel_err};
      tag2 <= tag1;
    end
  end

  // FIFO storage; out-of-range operations store a zero result.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= tag2.err ? '0 : sum_mod;
      fifo_id[wr_ptr]   <= ID_W'(tag2.id);
      fifo_err[wr_ptr]  <= tag2.err;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Head of FIFO drives the result port; zeros when empty.
  always_comb begin
    res_valid = (fifo_cnt != '0);
    res_data  = res_valid ? fifo_data[rd_ptr] : '0;
    res_id    = res_valid ? fifo_id[rd_ptr]   : '0;
    res_err   = res_valid ? fifo_err[rd_ptr]  : 1'b0;
    busy      = (cnt != '0);
  end

endmodule
